vector_mac_engine: RTL
======================

VECTOR_MAC_ENGINE -- requirements
Module: vector_mac_engine

Interface
REQ-001 SHALL have parameter VECTOR_LEN, default 96, the number of element pairs per dot product.
REQ-002 SHALL have parameter LANES, default 12, the element pairs accepted per beat; VECTOR_LEN SHALL be an integer multiple of LANES (BEATS = VECTOR_LEN/LANES).
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 5, the unsigned operand width (weight and feature).
REQ-004 SHALL have parameter DOT_PROD_WIDTH, default 16, the accumulator and result width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port flush, input, 1, synchronous abort of the current vector.
REQ-008 SHALL have port in_valid, input, 1, beat present.
REQ-009 SHALL have port in_ready, output, 1, beat may be accepted.
REQ-010 SHALL have port weight_line, input, array [0:LANES-1] of WEIGHT_WIDTH, weights of the beat.
REQ-011 SHALL have port feature_line, input, array [0:LANES-1] of WEIGHT_WIDTH, features of the beat.
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-014 SHALL have port dot_out, output, DOT_PROD_WIDTH, dot-product result.
REQ-015 SHALL have port overflow, output, 1, sticky per-vector flag: accumulation exceeded 2^DOT_PROD_WIDTH-1.

Function
REQ-016 SHALL accept a beat only on a cycle with in_valid=1 and in_ready=1; in_ready = 1 in IDLE and ACCUM, 0 in DONE.
REQ-017 SHALL compute beat_sum = sum over lanes of weight_line[i]*feature_line[i], unsigned, at full width (2*WEIGHT_WIDTH + clog2(LANES) bits), with no truncation before accumulation.
REQ-018 SHALL implement FSM states IDLE, ACCUM, DONE; IDLE: acc=0, beat_cnt=0, overflow=0.
REQ-019 SHALL, on an accepted beat in IDLE or ACCUM, set acc <= acc + beat_sum and beat_cnt <= beat_cnt+1; when the accepted beat is beat BEATS-1, go to DONE, otherwise go to or stay in ACCUM.
REQ-020 SHALL handle BEATS=1: a single accepted beat in IDLE goes directly to DONE.
REQ-021 SHALL, in DONE, hold out_valid=1 with dot_out and overflow stable until out_ready=1, then return to IDLE next cycle (clearing acc, beat_cnt and overflow).
REQ-022 SHALL produce out_valid exactly one cycle after the final beat is accepted; a cycle with in_valid=0 SHALL leave all state unchanged.
REQ-023 SHALL keep out_valid=0 outside DONE, with dot_out held at its last value.
REQ-024 SHALL set overflow when acc + beat_sum > 2^DOT_PROD_WIDTH-1 on any beat of the vector; once set it stays set until the return to IDLE.
REQ-025 SHALL, without the macro, wrap acc modulo 2^DOT_PROD_WIDTH.
REQ-026 SHALL, on flush=1 in any state, go to IDLE next cycle and discard acc; a beat offered in that cycle SHALL be dropped, and a pending result in DONE SHALL be dropped.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, enter IDLE: out_valid=0, dot_out=0, overflow=0, acc=0, beat_cnt=0; in_ready=1 from the first cycle after reset deasserts.
REQ-028 SHALL give reset priority over flush and over any handshake in the same cycle; reset mid-vector SHALL discard all partial state.

Configuration
REQ-029 SHALL, when macro VECTOR_MAC_SATURATE_EN is defined, clamp acc to 2^DOT_PROD_WIDTH-1 on overflow and hold it there for the rest of the vector, with overflow still flagged.
REQ-030 SHALL, when VECTOR_MAC_SATURATE_EN is not defined, wrap per REQ-025; ports are identical in both builds.

Verification (defaults: BEATS=8)
REQ-031 SHALL cover: 8 back-to-back beats of all weights=1, features=1 -> out_valid one cycle after beat 8; dot_out=96; overflow=0.
REQ-032 SHALL cover: all operands=31 (96*961=92256) -> dot_out=26720 and overflow=1 without the macro; dot_out=65535 and overflow=1 with VECTOR_MAC_SATURATE_EN.
REQ-033 SHALL cover: out_ready low for 5 cycles in DONE -> out_valid, dot_out and overflow stable, in_ready=0; IDLE on the cycle after out_ready=1.
REQ-034 SHALL cover: 8 beats of weights=2, features=3 with random in_valid gaps -> dot_out=576, same as the gap-free run.
REQ-035 SHALL cover: flush after 3 beats, then a full vector of weights=1, features=4 -> dot_out=384, with no contribution from the flushed beats.
REQ-036 SHALL cover: reset asserted after 5 beats, then a full vector of weights=1, features=1 -> dot_out=96; out_valid=0 during and right after reset.

Source files
------------

// File: rtl/vector_mac_engine.sv
// vector_mac_engine: streaming unsigned dot-product engine.
// Each accepted beat carries LANES weight/feature pairs. After VECTOR_LEN/LANES beats
// the accumulated dot product is presented on dot_out with a valid/ready handshake.
// Optional build macro: VECTOR_MAC_SATURATE_EN. When defined, the accumulator clamps
// at 2^DOT_PROD_WIDTH-1 on overflow. When undefined (default), it wraps modulo
// 2^DOT_PROD_WIDTH. The overflow flag is raised in both builds.
module vector_mac_engine #(
    parameter int unsigned VECTOR_LEN     = 96,
    parameter int unsigned LANES          = 12,
    parameter int unsigned WEIGHT_WIDTH   = 5,
    parameter int unsigned DOT_PROD_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WEIGHT_WIDTH-1:0]   weight_line  [0:LANES-1],
    input  logic [WEIGHT_WIDTH-1:0]   feature_line [0:LANES-1],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DOT_PROD_WIDTH-1:0] dot_out,
    output logic                      overflow
);

    localparam int unsigned BEATS = VECTOR_LEN / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Full-precision beat sum: product width plus growth from adding LANES products.
    localparam int unsigned SUM_W = 2 * WEIGHT_WIDTH + $clog2(LANES);
    // One bit wider than the larger addend, so the carry out of acc + beat_sum is visible.
    localparam int unsigned EXT_W = ((DOT_PROD_WIDTH > SUM_W) ? DOT_PROD_WIDTH : SUM_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef VECTOR_MAC_SATURATE_EN
    localparam logic [DOT_PROD_WIDTH-1:0] ACC_MAX = '1;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [DOT_PROD_WIDTH-1:0] r_acc;
    logic [DOT_PROD_WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0]          r_beat_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic                      r_ovf;
    logic                      w_ovf_nxt;
    logic [DOT_PROD_WIDTH-1:0] r_dot;
    logic [DOT_PROD_WIDTH-1:0] w_dot_nxt;

    logic [SUM_W-1:0]          w_beat_sum;
    logic [EXT_W-1:0]          w_sum_ext;
    logic                      w_beat_ovf;
    logic [DOT_PROD_WIDTH-1:0] w_acc_add;
    logic                      w_accept;
    logic                      w_last_beat;

    // Sum of all lane products for the current beat, kept at full width.
    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_beat_sum = w_beat_sum + (SUM_W'(weight_line[i]) * SUM_W'(feature_line[i]));
        end
    end

    assign w_sum_ext   = EXT_W'(r_acc) + EXT_W'(w_beat_sum);
    // Any bit above the accumulator width means acc + beat_sum exceeded 2^DOT_PROD_WIDTH-1.
    assign w_beat_ovf  = |w_sum_ext[EXT_W-1:DOT_PROD_WIDTH];
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);

`ifdef VECTOR_MAC_SATURATE_EN
    // Once clamped, acc stays at ACC_MAX: any further non-zero sum overflows again.
    assign w_acc_add = w_beat_ovf ? ACC_MAX : w_sum_ext[DOT_PROD_WIDTH-1:0];
`else
    assign w_acc_add = w_sum_ext[DOT_PROD_WIDTH-1:0];
`endif

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_beat_cnt;
        w_ovf_nxt   = r_ovf;
        w_dot_nxt   = r_dot;
        in_ready    = (r_state != StDone);
        out_valid   = (r_state == StDone);
        w_accept    = in_valid && in_ready;

        if (flush) begin
            // Abort: drop any offered beat and any pending result. dot_out keeps its value.
            w_state_nxt = StIdle;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StAccum: begin
                    if (w_accept) begin
                        w_acc_nxt = w_acc_add;
                        w_cnt_nxt = r_beat_cnt + CNT_W'(1);
                        w_ovf_nxt = r_ovf | w_beat_ovf;
                        if (w_last_beat) begin
                            w_state_nxt = StDone;
                            w_dot_nxt   = w_acc_add;
                        end else begin
                            w_state_nxt = StAccum;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        w_state_nxt = StIdle;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    // State register. Reset takes priority over flush and handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, beat counter, sticky overflow and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_ovf      <= 1'b0;
            r_dot      <= '0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
            r_dot      <= w_dot_nxt;
        end
    end

    assign dot_out  = r_dot;
    assign overflow = r_ovf;

endmodule
